// File: rtl/atm_ctrl_multi.sv
// Multi-account ATM transaction controller: per-account balance/PIN/lock
// registers, PIN retry limit with card retention, per-session withdrawal
// cap, inactivity timeout and a one-cycle registered result strobe.
module atm_ctrl_multi #(
  parameter int unsigned BAL_W       = 32,
  parameter int unsigned PIN_W       = 4,
  parameter int unsigned N_ACCT      = 4,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned TIMEOUT     = 16,
  parameter logic [BAL_W-1:0] INIT_BAL    = 32'h000F4240,
  parameter logic [PIN_W-1:0] DEFAULT_PIN = 4'b1010,
  parameter logic [BAL_W-1:0] WD_LIMIT    = 32'd50000,
  localparam int unsigned AW = (N_ACCT > 1) ? $clog2(N_ACCT) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             card_in,
  input  logic [AW-1:0]    acct_id,
  input  logic [PIN_W-1:0] pin,
  input  logic             pin_valid,
  input  logic [1:0]       op_code,
  input  logic [BAL_W-1:0] amount,
  input  logic             op_valid,
  input  logic             eject_req,
  output logic [BAL_W-1:0] balance,
  output logic [2:0]       status,
  output logic             rsp_valid,
  output logic             eject,
  output logic             retain,
  output logic             busy
);

  localparam int unsigned TW = (MAX_TRIES > 0) ? $clog2(MAX_TRIES + 1) : 1;
  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PIN, S_CHOOSE, S_EXEC, S_SHOW, S_EJECT, S_WAIT_OUT, S_RETAIN
  } state_e;

  typedef enum logic [2:0] {
    ST_OK, ST_BAD_PIN, ST_INSUFF, ST_OVERFLOW, ST_LIMIT, ST_LOCKED, ST_TIMEOUT
  } status_e;

  state_e           state, state_d;
  logic [AW-1:0]    acct;
  logic [TW-1:0]    tries, tries_nxt;
  logic [CW-1:0]    timer;
  logic [1:0]       op_q;
  logic [BAL_W-1:0] amt_q, sess;
  status_e          res, res_d, stat_d;
  logic             pend, pend_d;

  logic [BAL_W-1:0] bal  [N_ACCT];
  logic [PIN_W-1:0] pins [N_ACCT];
  logic [N_ACCT-1:0] lock;

  logic             acct_ok, id_ok, id_locked;
  logic [BAL_W-1:0] bal_sel, bal_wd;
  logic [BAL_W:0]   dep_sum, wd_sum;
  logic [PIN_W-1:0] pin_wd;
  logic acct_ld, sess_clr, tries_clr, tries_inc, timer_clr, timer_inc, op_ld;
  logic bal_we, pin_we, lock_set, sess_we, res_ld, rsp_d, eject_d, retain_d;

  // Account lookup and the wide arithmetic used for overflow/limit checks
  always_comb begin
    acct_ok   = {1'b0, acct} < (AW+1)'(N_ACCT);
    id_ok     = {1'b0, acct_id} < (AW+1)'(N_ACCT);
    id_locked = id_ok && lock[acct_id];
    bal_sel   = acct_ok ? bal[acct] : '0;
    dep_sum   = {1'b0, bal_sel} + {1'b0, amt_q};
    wd_sum    = {1'b0, sess} + {1'b0, amt_q};
    tries_nxt = tries + TW'(1);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_d;
  end

  // Next-state logic and per-cycle control decisions
  always_comb begin
    state_d = state;   acct_ld = 1'b0;   sess_clr = 1'b0;  tries_clr = 1'b0;
    tries_inc = 1'b0;  timer_clr = 1'b0; timer_inc = 1'b0; op_ld = 1'b0;
    bal_we = 1'b0;     bal_wd = bal_sel; pin_we = 1'b0;    pin_wd = amt_q[PIN_W-1:0];
    lock_set = 1'b0;   sess_we = 1'b0;   res_ld = 1'b0;    res_d = res;
    pend_d = pend;     rsp_d = 1'b0;     stat_d = res;     eject_d = 1'b0;
    retain_d = 1'b0;
    case (state)
      S_IDLE: if (card_in) begin
        acct_ld = 1'b1;
        if (!id_ok || id_locked) begin
          res_ld = 1'b1; res_d = ST_LOCKED; pend_d = 1'b1; state_d = S_EJECT;
        end else begin
          tries_clr = 1'b1; sess_clr = 1'b1; timer_clr = 1'b1; pend_d = 1'b0;
          state_d = S_PIN;
        end
      end
      S_PIN: begin
        if (!card_in) state_d = S_IDLE;
        else if (pin_valid) begin
          timer_clr = 1'b1;
          if (pin == pins[acct]) state_d = S_CHOOSE;
          else begin
            rsp_d = 1'b1; stat_d = ST_BAD_PIN; tries_inc = 1'b1;
            if (tries_nxt == TW'(MAX_TRIES)) begin
              lock_set = 1'b1; state_d = S_RETAIN;
            end
          end
        end else if (timer == CW'(TIMEOUT - 1)) begin
          res_ld = 1'b1; res_d = ST_TIMEOUT; pend_d = 1'b1; state_d = S_EJECT;
        end else timer_inc = 1'b1;
      end
      S_CHOOSE: begin
        if (!card_in) state_d = S_IDLE;
        else if (eject_req) begin
          pend_d = 1'b0; state_d = S_EJECT;
        end else if (op_valid) begin
          op_ld = 1'b1; timer_clr = 1'b1; state_d = S_EXEC;
        end else if (timer == CW'(TIMEOUT - 1)) begin
          res_ld = 1'b1; res_d = ST_TIMEOUT; pend_d = 1'b1; state_d = S_EJECT;
        end else timer_inc = 1'b1;
      end
      S_EXEC: begin
        res_ld = 1'b1; res_d = ST_OK; state_d = S_SHOW;
        case (op_q)
          2'b00: if (dep_sum[BAL_W]) res_d = ST_OVERFLOW;
                 else begin bal_we = 1'b1; bal_wd = dep_sum[BAL_W-1:0]; end
          2'b01: if (amt_q > bal_sel) res_d = ST_INSUFF;
                 else if (wd_sum > {1'b0, WD_LIMIT}) res_d = ST_LIMIT;
                 else begin
                   bal_we = 1'b1; bal_wd = bal_sel - amt_q; sess_we = 1'b1;
                 end
          2'b10: res_d = ST_OK;
          2'b11: pin_we = 1'b1;
        endcase
      end
      S_SHOW: begin
        rsp_d = 1'b1; stat_d = res; timer_clr = 1'b1; state_d = S_CHOOSE;
      end
      S_EJECT: begin
        eject_d = 1'b1; rsp_d = pend; stat_d = res; pend_d = 1'b0;
        state_d = S_WAIT_OUT;
      end
      S_WAIT_OUT: if (!card_in) state_d = S_IDLE;
      S_RETAIN: begin
        retain_d = 1'b1; state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Session registers and registered outputs; the balance reported with a
  // strobe is read after EXEC has written it, so SHOW sees the new value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acct <= '0;  tries <= '0;  timer <= '0;  op_q <= '0;  amt_q <= '0;
      sess <= '0;  res <= ST_OK; pend <= 1'b0;
      balance <= '0; status <= '0; rsp_valid <= 1'b0;
      eject <= 1'b0; retain <= 1'b0; busy <= 1'b0;
    end else begin
      if (acct_ld) acct <= acct_id;
      if (tries_clr)      tries <= '0;
      else if (tries_inc) tries <= tries_nxt;
      if (timer_clr)      timer <= '0;
      else if (timer_inc) timer <= timer + CW'(1);
      if (op_ld) begin
        op_q  <= op_code;
        amt_q <= amount;
      end
      if (sess_clr)     sess <= '0;
      else if (sess_we) sess <= wd_sum[BAL_W-1:0];
      if (res_ld) res <= res_d;
      pend      <= pend_d;
      rsp_valid <= rsp_d;
      eject     <= eject_d;
      retain    <= retain_d;
      busy      <= (state_d != S_IDLE);
      if (rsp_d) begin
        status  <= stat_d;
        balance <= bal_sel;
      end
    end
  end

  // Per-account balance, PIN and lock storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N_ACCT; i++) begin
        bal[i]  <= INIT_BAL;
        pins[i] <= DEFAULT_PIN;
      end
      lock <= '0;
    end else begin
      if (bal_we)   bal[acct]  <= bal_wd;
      if (pin_we)   pins[acct] <= pin_wd;
      if (lock_set) lock[acct] <= 1'b1;
    end
  end

endmodule
